// File: rtl/wb_host_master.sv
// rtl/wb_host_master.sv - single-transfer Wishbone B3 classic initiator driven by a valid/ready command stream
// Optional ack timeout enabled by defining WBM_TIMEOUT_EN.
module wb_host_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rstn_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_adr,
  input  logic [DATA_W-1:0]   cmd_dat,
  input  logic [DATA_W/8-1:0] cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_dat,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [DATA_W-1:0]   wbm_dat_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t              state_q, state_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic                we_q, we_d;
  logic [DATA_W/8-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic                rsp_err_q, rsp_err_d;
  logic                timeout_hit;

`ifdef WBM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter saturates at CNT_MAX; it is cleared only when the response is consumed.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == BUS && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    if (state_q == RESP && rsp_ready) cnt_d = '0;
  end

  // Fires on the edge at which the counter would reach CNT_MAX.
  assign timeout_hit = (state_q == BUS) && (cnt_q == CNT_MAX - 1'b1);

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end
`else
  localparam int timeout_cycles_unused = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          state_d     = RESP;
        end else if (timeout_hit) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_host_master.sv
// tb/tb_wb_host_master.sv - scoreboard bench for wb_host_master with a configurable Wishbone slave
module tb_wb_host_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = '0;

  typedef struct packed { logic [31:0] dat; logic err; } rsp_t;
  rsp_t exp_q[$];

  int n_tests = 0, n_fail = 0;

  logic        ack_en = 1'b1, force_ack = 1'b0;
  int          ack_wait = 0, wcnt = 0;
  logic [31:0] slave_dat = '0;

  wb_host_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i(clk), .wb_rstn_i(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave: acks after ack_wait cycles of cyc&stb; force_ack drives ack regardless of bus state.
  always @(negedge clk) begin
    wbm_ack_i = force_ack;
    if (wbm_cyc_o && wbm_stb_o) begin
      if (ack_en && wcnt == ack_wait) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = slave_dat;
      end
      wcnt++;
    end else begin
      wcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got dat=0x%0h err=%0b expected no response", rsp_dat, rsp_err);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_dat", {32'h0, rsp_dat}, {32'h0, e.dat});
        check("rsp_err", {63'h0, rsp_err}, {63'h0, e.err});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic push, input logic [31:0] edat,
                        input logic eerr);
    int t;
    rsp_t e;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("cmd_accept_bound", {63'h0, (t < 100)}, 64'h1);
    if (push) begin
      e.dat = edat;
      e.err = eerr;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("bus_cyc", {63'h0, wbm_cyc_o}, 64'h1);
    check("bus_stb", {63'h0, wbm_stb_o}, 64'h1);
    check("bus_we", {63'h0, wbm_we_o}, {63'h0, we});
    check("bus_adr", {32'h0, wbm_adr_o}, {32'h0, adr});
    check("bus_dat", {32'h0, wbm_dat_o}, {32'h0, dat});
    check("bus_sel", {60'h0, wbm_sel_o}, {60'h0, sel});
  endtask

  // Counts negedges with cyc high; flags any cycle where cmd_ready or stb disagree.
  task automatic cyc_cycles(input int exp_n, input string name);
    int n;
    logic bad;
    n = 0;
    bad = 1'b0;
    @(negedge clk);
    while (wbm_cyc_o && n < 50) begin
      if (cmd_ready || !wbm_stb_o) bad = 1'b1;
      n++;
      @(negedge clk);
    end
    check(name, 64'(n), 64'(exp_n));
    check({name, "_ready_low"}, {63'h0, bad}, 64'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_cmd_ready", {63'h0, cmd_ready}, 64'h1);
    check("rst_cyc", {63'h0, wbm_cyc_o}, 64'h0);
    check("rst_stb", {63'h0, wbm_stb_o}, 64'h0);
    check("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    check("rst_rsp_dat", {32'h0, rsp_dat}, 64'h0);
    check("rst_adr", {32'h0, wbm_adr_o}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    ack_en = 1'b1; ack_wait = 0; rsp_ready = 1'b1;
    do_cmd(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, 1'b0);
    cyc_cycles(1, "write_cyc_len");
    check("write_retain_adr", {32'h0, wbm_adr_o}, 64'h3000_0004);

    ack_wait = 3; slave_dat = 32'h1234_5678;
    do_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b1, 32'h1234_5678, 1'b0);
    cyc_cycles(4, "read_cyc_len");

    rsp_ready = 1'b0; ack_wait = 0; slave_dat = 32'hCAFE_F00D;
    do_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF, 1'b1, 32'hCAFE_F00D, 1'b0);
    cyc_cycles(1, "bp_cyc_len");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {63'h0, rsp_valid}, 64'h1);
      check("bp_dat", {32'h0, rsp_dat}, 64'hCAFE_F00D);
      check("bp_cmd_ready", {63'h0, cmd_ready}, 64'h0);
      check("bp_cyc", {63'h0, wbm_cyc_o}, 64'h0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_000C; cmd_dat = 32'hA5A5_5A5A; cmd_sel = 4'h3;
    exp_q.push_back('{dat: 32'h0, err: 1'b0});
    @(posedge clk); #1;
    check("bp_after_valid", {63'h0, rsp_valid}, 64'h0);
    check("bp_after_ready", {63'h0, cmd_ready}, 64'h1);
    check("bp_after_cyc", {63'h0, wbm_cyc_o}, 64'h0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("queued_cyc", {63'h0, wbm_cyc_o}, 64'h1);
    check("queued_adr", {32'h0, wbm_adr_o}, 64'h3000_000C);
    check("queued_sel", {60'h0, wbm_sel_o}, 64'h3);
    cyc_cycles(1, "queued_cyc_len");

    ack_en = 1'b0;
    do_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rstmid_cyc", {63'h0, wbm_cyc_o}, 64'h0);
    check("rstmid_stb", {63'h0, wbm_stb_o}, 64'h0);
    check("rstmid_valid", {63'h0, rsp_valid}, 64'h0);
    check("rstmid_ready", {63'h0, cmd_ready}, 64'h1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ack_en = 1'b1; ack_wait = 1; slave_dat = 32'h0BAD_CAFE;
    @(posedge clk); #1;
    do_cmd(1'b0, 32'h3000_0014, 32'h0, 4'h1, 1'b1, 32'h0BAD_CAFE, 1'b0);
    cyc_cycles(2, "post_rst_cyc_len");

`ifdef WBM_TIMEOUT_EN
    ack_en = 1'b0; rsp_ready = 1'b0;
    do_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1);
    cyc_cycles(4, "timeout_cyc_len");
    check("to_valid", {63'h0, rsp_valid}, 64'h1);
    check("to_err", {63'h0, rsp_err}, 64'h1);
    check("to_dat", {32'h0, rsp_dat}, 64'h0);
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("to_late_ack_valid", {63'h0, rsp_valid}, 64'h1);
    check("to_late_ack_err", {63'h0, rsp_err}, 64'h1);
    force_ack = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ack_en = 1'b1; ack_wait = 3; slave_dat = 32'h600D_DA7A;
    do_cmd(1'b0, 32'h3000_0024, 32'h0, 4'hF, 1'b1, 32'h600D_DA7A, 1'b0);
    cyc_cycles(4, "tie_cyc_len");
`endif

    repeat (5) @(posedge clk);
    #1;
    check("rsp_queue_empty", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
